// File: rtl/instr_mem_server.sv
// instr_mem_server: 64x16 instruction memory read combinationally by the CPU and reloaded over a
// byte-wide valid/ready port. Define INSTR_MEM_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_mem_server #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic [5:0]  PC,
    output logic [15:0] Instruct,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
`ifdef INSTR_MEM_CHECKSUM_EN
        CHK  = 3'd4,
`endif
        DONE = 3'd5
    } state_e;

    localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [6:0]  rem_q, rem_d;
    logic [7:0]  hi_q, hi_d;
    logic        err_q, err_d;
    logic [15:0] timer_q, timer_d;
`ifdef INSTR_MEM_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        busy;
    logic        xfer;
    logic        timeout_hit;
    logic        mem_we;
    logic [16:0] idle_next;

    // NOTE: the storage array has no reset; a reload is the only way to change it, and its
    // power-up contents (all zero) come from device configuration.
    logic [15:0] mem_q [64];

    // Every state between the load_start and the DONE pulse is a byte-accepting state.
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign byte_ready  = busy;
    assign cpu_hold    = (state_q != IDLE);
    assign load_done   = (state_q == DONE);
    assign load_err    = err_q;
    assign xfer        = byte_valid && busy;
    assign idle_next   = {1'b0, timer_q} + 17'd1;
    assign timeout_hit = busy && !xfer && (idle_next == TIMEOUT_CNT);
    assign Instruct    = cpu_hold ? 16'h0000 : mem_q[PC];

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        err_d   = err_q;
        timer_d = timer_q;
        mem_we  = 1'b0;
`ifdef INSTR_MEM_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        if (busy) begin
            timer_d = xfer ? 16'd0 : idle_next[15:0];
        end

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    err_d   = 1'b0;
                    addr_d  = 6'd0;
                    timer_d = 16'd0;
`ifdef INSTR_MEM_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = LEN;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (byte_data[7] || (byte_data[6:0] > 7'd64)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d   = (byte_data[6:0] == 7'd0) ? 7'd64 : byte_data[6:0];
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
`ifdef INSTR_MEM_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_data;
`endif
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + 6'd1;
`ifdef INSTR_MEM_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (rem_q == 7'd1) begin
`ifdef INSTR_MEM_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        rem_d   = rem_q - 7'd1;
                        state_d = HI;
                    end
                end
            end
`ifdef INSTR_MEM_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled loader abandons the load; words already written stay in memory.
        if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 6'd0;
            rem_q   <= 7'd0;
            hi_q    <= 8'h00;
            err_q   <= 1'b0;
            timer_q <= 16'd0;
`ifdef INSTR_MEM_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            timer_q <= timer_d;
`ifdef INSTR_MEM_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // A word arriving on the same edge as reset is dropped; everything written earlier survives.
    always_ff @(posedge clk_main) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= {hi_q, byte_data};
        end
    end

endmodule

// File: tb/tb_instr_mem_server.sv
// Self-checking bench for instr_mem_server: table-driven loads plus hand-written corner sequences,
// with a reference memory model and a readback scoreboard queue.
module tb_instr_mem_server;

    localparam int unsigned TO   = 4;
    localparam int          NVEC = 6;

    logic        clk_main   = 1'b0;
    logic        reset      = 1'b1;
    logic [5:0]  PC         = 6'd0;
    logic [15:0] Instruct;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        byte_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model_mem [64];
    logic [15:0] exp_q [$];
    logic [15:0] wq [$];

    typedef struct {
        logic [7:0]  len_byte;
        int          gap;
        logic [15:0] seed;
        logic [7:0]  chk_flip;
    } load_vec_t;

    load_vec_t vecs [NVEC];

    instr_mem_server #(.TIMEOUT(TO)) dut (
        .clk_main   (clk_main),
        .reset      (reset),
        .PC         (PC),
        .Instruct   (Instruct),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk_main = ~clk_main;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit ls);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        load_start = ls;
        #1;
        check("byte_ready", byte_ready, 1);
        check("instr_nop_during_load", Instruct, 16'h0000);
        check("done_low_during_load", load_done, 0);
        tick();
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic readback_all();
        for (int pc = 0; pc < 64; pc++) begin
            PC = 6'(pc);
            exp_q.push_back(model_mem[pc]);
            #1;
            check($sformatf("readback_pc%0d", pc), Instruct, exp_q.pop_front());
        end
    endtask

    task automatic run_load(input logic [7:0] len_byte, input logic [15:0] words [$],
                            input int gap, input logic [7:0] chk_flip, input bit ls_mid);
        logic [7:0] csum;
        logic [7:0] hi;
        logic [7:0] lo;
        int         n;
        bit         len_bad;
        bit         exp_err;
        len_bad = len_byte[7] || (len_byte[6:0] > 7'd64);
        n       = (len_byte[6:0] == 7'd0) ? 64 : int'(len_byte[6:0]);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_hold", cpu_hold, 1);
        check("start_ready", byte_ready, 1);
        check("start_err_cleared", load_err, 0);
        send_byte(len_byte, gap, 1'b0);
        if (len_bad) begin
            check("len_err", load_err, 1);
            check("len_err_hold", cpu_hold, 0);
            check("len_err_ready", byte_ready, 0);
            check("len_err_no_done", load_done, 0);
            return;
        end
        csum = 8'h00;
        for (int i = 0; i < n; i++) begin
            hi = words[i][15:8];
            lo = words[i][7:0];
            send_byte(hi, gap, ls_mid && (i == 1));
            send_byte(lo, gap, 1'b0);
            model_mem[i % 64] = words[i];
            csum = csum ^ hi ^ lo;
        end
        exp_err = 1'b0;
`ifdef INSTR_MEM_CHECKSUM_EN
        send_byte(csum ^ chk_flip, gap, 1'b0);
        exp_err = (chk_flip != 8'h00);
`endif
        if (exp_err) begin
            check("chk_err", load_err, 1);
            check("chk_no_done", load_done, 0);
            check("chk_err_hold", cpu_hold, 0);
        end else begin
            check("done_pulse", load_done, 1);
            check("done_hold", cpu_hold, 1);
            check("done_err", load_err, 0);
            tick();
            check("done_gone", load_done, 0);
            check("hold_released", cpu_hold, 0);
            check("ready_released", byte_ready, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;

        vecs[0] = '{8'h00, 0,      16'h3C00, 8'h00};
        vecs[1] = '{8'h41, 0,      16'h0000, 8'h00};
        vecs[2] = '{8'h80, 1,      16'h0000, 8'h00};
        vecs[3] = '{8'h40, 1,      16'h5A5A, 8'h00};
        vecs[4] = '{8'h05, TO - 1, 16'hC001, 8'h00};
        vecs[5] = '{8'h02, 2,      16'h7E00, 8'h5A};

        // Reset state and initial memory contents.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_byte_ready", byte_ready, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        readback_all();

        // Table-driven loads: length encodings, stalls below the timeout, checksum mismatch.
        for (int v = 0; v < NVEC; v++) begin
            wq.delete();
            for (int i = 0; i < 64; i++) wq.push_back(16'(vecs[v].seed + 16'(i) * 16'h0101));
            run_load(vecs[v].len_byte, wq, vecs[v].gap, vecs[v].chk_flip, 1'b0);
            readback_all();
        end

        // Three back-to-back words, a stray load_start mid-load, PC parked on a nonzero word.
        PC = 6'd10;
        wq.delete();
        wq.push_back(16'hA5C3);
        wq.push_back(16'h1234);
        wq.push_back(16'hFFFF);
        run_load(8'h03, wq, 0, 8'h00, 1'b1);
        PC = 6'd1;
        #1;
        check("pc1_after_load", Instruct, 16'h1234);
        readback_all();

        // Loader stalls after the HI byte of word 2.
        PC = 6'd10;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'hBE, 0, 1'b0);
        send_byte(8'hEF, 0, 1'b0);
        model_mem[0] = 16'hBEEF;
        send_byte(8'hCA, 0, 1'b0);
        for (int k = 1; k < int'(TO); k++) begin
            tick();
            check("to_wait_err", load_err, 0);
            check("to_wait_hold", cpu_hold, 1);
        end
        tick();
        check("to_err", load_err, 1);
        check("to_hold", cpu_hold, 0);
        check("to_ready", byte_ready, 0);
        readback_all();

        // Reset clears the sticky error.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_clears_err", load_err, 0);

        // Reset lands on the LO byte of word 2.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h57, 0, 1'b0);
        model_mem[0] = 16'h1357;
        send_byte(8'h24, 0, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'h68;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        byte_valid = 1'b0;
        check("midrst_hold", cpu_hold, 0);
        check("midrst_ready", byte_ready, 0);
        check("midrst_done", load_done, 0);
        check("midrst_err", load_err, 0);
        tick();
        check("midrst_stays_idle", cpu_hold, 0);
        readback_all();

`ifdef INSTR_MEM_CHECKSUM_EN
        // Single word 16'h0F0F: XOR is 8'h00, so 8'h00 passes and 8'h01 fails.
        wq.delete();
        wq.push_back(16'h0F0F);
        run_load(8'h01, wq, 0, 8'h00, 1'b0);
        readback_all();
        run_load(8'h01, wq, 0, 8'h01, 1'b0);
        readback_all();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
